// File: rtl/result_display_pkg.sv
// Shared definitions for result_display: active-low glyphs, FSM states, display width.
// RESULT_DISPLAY_BCD_EN selects decimal display with a CONVERT state; otherwise the word is shown in hex.
package result_display_pkg;

  localparam int DISP_W = 16;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // In decimal mode a nibble of 4'hF marks a dash; the all-dash word flags overflow.
  localparam logic [3:0]        DASH_CODE   = 4'hF;
  localparam logic [DISP_W-1:0] DISP_DASHES = {(DISP_W/4){DASH_CODE}};

`ifdef RESULT_DISPLAY_BCD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_DWELL} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_DWELL} state_t;
`endif

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] dec_glyph(input logic [3:0] v);
    logic [6:0] g;
    if (v <= 4'd9)
      g = hex_glyph(v);
    else if (v == DASH_CODE)
      g = SEG_DASH;
    else
      g = SEG_BLANK;
    return g;
  endfunction

endpackage

// File: rtl/result_display_bcd_convert.sv
// Sequential double-dabble: one bit per cycle over N cycles, starting from bin when start is high.
// done and bcd are valid together during the cycle whose closing edge performs the final step.
module bcd_convert import result_display_pkg::*; #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [N-1:0]      bin,
  output logic              done,
  output logic [DISP_W-1:0] bcd,
  output logic              ovf
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]      sh_q;
  logic [N-1:0]      src;
  logic [DISP_W-1:0] bcd_q;
  logic [DISP_W-1:0] adj;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              ovf_q;
  logic              big;

  // Only four digits are kept; anything above 9999 is flagged instead of converted.
  if (N > 13) begin : g_wide
    assign big = (bin > N'(9999));
  end else begin : g_narrow
    assign big = 1'b0;
  end

  always_comb begin
    src = start ? bin : sh_q;
    adj = start ? '0 : bcd_q;
    for (int i = 0; i < DISP_W / 4; i++) begin
      if (adj[4*i +: 4] > 4'd4)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  assign bcd  = {adj[DISP_W-2:0], src[N-1]};
  assign done = start ? (N == 1) : (busy_q && (cnt_q == CW'(1)));
  assign ovf  = start ? big : ovf_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      sh_q   <= src << 1;
      bcd_q  <= bcd;
      cnt_q  <= CW'(N - 1);
      busy_q <= (N > 1);
      ovf_q  <= big;
    end else if (busy_q) begin
      sh_q  <= src << 1;
      bcd_q <= bcd;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/result_display.sv
// Accepts result words over a valid/ready handshake, holds each for DWELL cycles and scans it onto
// a 4-digit active-low seven-segment display. Define RESULT_DISPLAY_BCD_EN for decimal output.
module result_display import result_display_pkg::*; #(
  parameter int N           = 16,
  parameter int DWELL       = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         dp
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            state;
  state_t            state_next;
  logic [N-1:0]      cap;
  logic [DW-1:0]     dwell_cnt;
  logic              accept;
  logic              dwell_last;
  logic [DISP_W-1:0] disp;

  assign in_ready   = (state == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign dwell_last = (dwell_cnt == DW'(DWELL - 1));
  assign dp         = 1'b1;

  always_ff @(posedge clk) begin
    if (!nrst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cap       <= '0;
      dwell_cnt <= '0;
    end else begin
      if (accept)
        cap <= in0;
      if (state == ST_DWELL && !dwell_last)
        dwell_cnt <= dwell_cnt + DW'(1);
      else
        dwell_cnt <= '0;
    end
  end

`ifdef RESULT_DISPLAY_BCD_EN
  logic              start_q;
  logic              conv_done;
  logic              conv_ovf;
  logic [DISP_W-1:0] conv_bcd;

  // Conversion starts the cycle after accept so it reads the already-latched word.
  always_ff @(posedge clk) begin
    if (!nrst)
      start_q <= 1'b0;
    else
      start_q <= accept;
  end

  bcd_convert #(.N(N)) u_bcd (
    .clk   (clk),
    .nrst  (nrst),
    .start (start_q),
    .bin   (cap),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk) begin
    if (!nrst)
      disp <= '0;
    else if (state == ST_CONVERT && conv_done)
      disp <= conv_ovf ? DISP_DASHES : conv_bcd;
  end

  function automatic logic [6:0] digit_glyph(input logic [3:0] v);
    return dec_glyph(v);
  endfunction
`else
  assign disp = DISP_W'(cap);

  function automatic logic [6:0] digit_glyph(input logic [3:0] v);
    return hex_glyph(v);
  endfunction
`endif

  always_comb begin
    state_next = state;
    case (state)
`ifdef RESULT_DISPLAY_BCD_EN
      ST_IDLE:    if (accept) state_next = ST_CONVERT;
      ST_CONVERT: if (conv_done) state_next = ST_DWELL;
`else
      ST_IDLE:    if (accept) state_next = ST_DWELL;
`endif
      ST_DWELL:   if (dwell_last) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  logic [RW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          div_wrap;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic [3:0]    an_next;

  assign div_wrap = (div_cnt == RW'(REFRESH_DIV - 1));
  assign idx_next = div_wrap ? idx + 2'd1 : idx;
  assign an_next  = ~(4'b0001 << idx_next);

  // seg and an are computed from the same upcoming index so they always switch on one edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + RW'(1);
      idx     <= idx_next;
      an_q    <= an_next;
      seg_q   <= digit_glyph(disp[4*idx_next +: 4]);
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (N=16, DWELL=4, REFRESH_DIV=2).
// Compile with RESULT_DISPLAY_BCD_EN defined to exercise the decimal build instead of hex.
module tb_result_display;

  localparam int N           = 16;
  localparam int DWELL       = 4;
  localparam int REFRESH_DIV = 2;
`ifdef RESULT_DISPLAY_BCD_EN
  localparam int L = N + DWELL;
`else
  localparam int L = DWELL;
`endif

  localparam logic [6:0] G0    = 7'b1000000;
  localparam logic [6:0] G1    = 7'b1111001;
  localparam logic [6:0] G2    = 7'b0100100;
  localparam logic [6:0] G5    = 7'b0010010;
  localparam logic [6:0] G6    = 7'b0000010;
  localparam logic [6:0] G7    = 7'b1111000;
  localparam logic [6:0] G8    = 7'b0000000;
  localparam logic [6:0] GA    = 7'b0001000;
  localparam logic [6:0] GF    = 7'b0001110;
  localparam logic [6:0] GDASH = 7'b0111111;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in0 = '0;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic         dp;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  result_display #(.N(N), .DWELL(DWELL), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in0      (in0),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [N-1:0] word);
    in_valid = valid;
    in0      = word;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for the given digit to be lit, then compare its glyph.
  task automatic checkDigit(input string tag, input int digit, input logic [6:0] exp_seg);
    logic [3:0] pat;
    int guard;
    pat = 4'b0001 << digit;
    pat = ~pat;
    guard = 0;
    while (an !== pat && guard < 12) begin
      tick();
      guard++;
    end
    if (an !== pat)
      checkOutput({tag, "_anode"}, 32'(an), 32'(pat));
    else
      checkOutput(tag, 32'(seg), 32'(exp_seg));
  endtask

  task automatic measureBusy(output int low);
    low = 0;
    while (!in_ready && low < 60) begin
      low++;
      tick();
    end
  endtask

  task automatic waitReady();
    int guard;
    guard = 0;
    while (!in_ready && guard < 60) begin
      tick();
      guard++;
    end
  endtask

  int words[3] = '{3, 5, 8};
  int hs_cycle[4];
  int hs;
  int wi;
  int guard;
  int low;
  logic fire;

  initial begin
    $display("[TB] reset");
    applyStimulus(1'b0, '0);
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_an", 32'(an), 32'h0000000E);
    checkOutput("reset_seg", 32'(seg), 32'(G0));
    checkOutput("reset_dp", 32'(dp), 32'd1);
    tick();
    checkOutput("scan_hold", 32'(an), 32'h0000000E);
    tick();
    checkOutput("scan_step", 32'(an), 32'h0000000D);

`ifdef RESULT_DISPLAY_BCD_EN
    $display("[TB] decimal overflow");
    applyStimulus(1'b1, 16'd46368);
    tick();
    applyStimulus(1'b0, '0);
    measureBusy(low);
    checkOutput("ovf_busy", 32'(low), 32'(L));
    for (int d = 0; d < 4; d++) checkDigit("ovf_dash", d, GDASH);

    $display("[TB] decimal 6765");
    applyStimulus(1'b1, 16'd6765);
    tick();
    applyStimulus(1'b0, '0);
    measureBusy(low);
    checkOutput("dec_busy", 32'(low), 32'(L));
    checkDigit("dec_d0", 0, G5);
    checkDigit("dec_d1", 1, G6);
    checkDigit("dec_d2", 2, G7);
    checkDigit("dec_d3", 3, G6);
`else
    $display("[TB] hex accept");
    applyStimulus(1'b1, 16'h1A2F);
    tick();
    applyStimulus(1'b0, '0);
    measureBusy(low);
    checkOutput("hex_busy", 32'(low), 32'(L));
    checkDigit("hex_d0", 0, GF);
    checkDigit("hex_d1", 1, G2);
    checkDigit("hex_d2", 2, GA);
    checkDigit("hex_d3", 3, G1);
`endif

    $display("[TB] backpressure");
    waitReady();
    hs = 0;
    wi = 0;
    guard = 0;
    applyStimulus(1'b1, 16'(words[0]));
    while (wi < 3 && guard < 100) begin
      fire = in_valid && in_ready;
      tick();
      guard++;
      if (fire) begin
        if (hs < 4) hs_cycle[hs] = cycle;
        hs++;
        wi++;
        if (wi < 3) applyStimulus(1'b1, 16'(words[wi]));
        else        applyStimulus(1'b0, '0);
      end
    end
    applyStimulus(1'b0, '0);
    checkOutput("bp_handshakes", 32'(hs), 32'd3);
    checkOutput("bp_gap1", 32'(hs_cycle[1] - hs_cycle[0]), 32'(L + 1));
    checkOutput("bp_gap2", 32'(hs_cycle[2] - hs_cycle[1]), 32'(L + 1));
    waitReady();
    checkDigit("bp_last_d0", 0, G8);
    checkDigit("bp_last_d1", 1, G0);

    $display("[TB] reset mid-operation");
    waitReady();
    applyStimulus(1'b1, 16'h00FF);
    tick();
    applyStimulus(1'b0, '0);
    tick();
    tick();
    nrst = 1'b0;
    tick();
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_an", 32'(an), 32'h0000000E);
    checkOutput("rst_mid_seg", 32'(seg), 32'(G0));
    nrst = 1'b1;
    low = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!in_ready) low++;
    end
    checkOutput("rst_mid_no_busy", 32'(low), 32'd0);
    for (int d = 0; d < 4; d++) checkDigit("rst_mid_zero", d, G0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
